// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared states, opcodes and select encodings for the multi-cycle MIPS controller
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP
  } state_t;

  // ALU operation class handed to the decoder by the state machine
  typedef enum logic [2:0] {
    ALU_OP_NONE, ALU_OP_ADD, ALU_OP_SUB, ALU_OP_FUNCT, ALU_OP_IMM
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRC_B_REG    = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// rtl/multicycle_ctrl_alu_decoder.sv - maps ALU op class, opcode and funct to alu_ctrl, extender mode and bad-funct flag
module alu_decoder
  import multicycle_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       ext_op,
  output logic       illegal_funct
);

  always_comb begin
    alu_ctrl      = ALU_AND;
    ext_op        = 1'b0;
    illegal_funct = 1'b0;
    case (alu_op)
      ALU_OP_ADD: alu_ctrl = ALU_ADD;
      ALU_OP_SUB: alu_ctrl = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: illegal_funct = 1'b1;
        endcase
      end
      // ori zero-extends its immediate; addi sign-extends
      ALU_OP_IMM: begin
        if (opcode == OP_ORI) begin
          alu_ctrl = ALU_OR;
        end else begin
          alu_ctrl = ALU_ADD;
          ext_op   = 1'b1;
        end
      end
      default: alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM with memory wait timeout
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int ALU_CTRL_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  pc_write_cond,
  output logic                  i_or_d,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  mem_to_reg,
  output logic                  reg_dst,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic                  ext_op,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            pc_source,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  illegal,
  output logic                  mem_err,
  output logic [3:0]            state_dbg
);

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  alu_op_t    alu_op;
  logic [2:0] dec_alu_ctrl;
  logic       dec_ext_op, dec_illegal_funct;
  logic       ext_fixed, illegal_raw, mem_state, timeout;
  logic       unused_zero;

  // zero only gates the PC write inside the datapath
  assign unused_zero = zero;

  alu_decoder u_alu_decoder (
    .alu_op        (alu_op),
    .opcode        (opcode),
    .funct         (funct),
    .alu_ctrl      (dec_alu_ctrl),
    .ext_op        (dec_ext_op),
    .illegal_funct (dec_illegal_funct)
  );

  assign mem_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign timeout   = mem_state && !mem_ready && (wait_cnt == 8'(MEM_TIMEOUT - 1));

  always_comb begin
    alu_op = ALU_OP_NONE;
    case (state)
      FETCH, DECODE, MEM_ADDR: alu_op = ALU_OP_ADD;
      R_EXEC:                  alu_op = ALU_OP_FUNCT;
      I_EXEC, I_WB:            alu_op = ALU_OP_IMM;
      BRANCH:                  alu_op = ALU_OP_SUB;
      default:                 alu_op = ALU_OP_NONE;
    endcase
  end

  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    pc_source     = PC_SRC_ALU;
    ext_fixed     = 1'b0;
    illegal_raw   = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = SRC_B_IMM_SH;
        ext_fixed = 1'b1;
        case (opcode)
          OP_RTYPE:      state_next = R_EXEC;
          OP_LW, OP_SW:  state_next = MEM_ADDR;
          OP_BEQ:        state_next = BRANCH;
          OP_ADDI, OP_ORI: state_next = I_EXEC;
          OP_J:          state_next = JUMP;
          default: begin
            illegal_raw = 1'b1;
            state_next  = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        ext_fixed  = 1'b1;
        state_next = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_next = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_next = FETCH;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        if (dec_illegal_funct) begin
          illegal_raw = 1'b1;
          state_next  = FETCH;
        end else begin
          state_next = R_WB;
        end
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        state_next = FETCH;
      end
      I_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        state_next = I_WB;
      end
      I_WB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
        state_next    = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PC_SRC_JUMP;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
    if (timeout) state_next = FETCH;
  end

  // counter clears on any state change and on a FETCH self-restart after timeout
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (state_next != state || timeout) wait_cnt_next = 8'd0;
    else if (mem_state && !mem_ready) wait_cnt_next = wait_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  assign ext_op    = ext_fixed | dec_ext_op;
  assign alu_ctrl  = ALU_CTRL_W'(dec_alu_ctrl);
  assign illegal   = illegal_raw & ~reset;
  assign mem_err   = timeout & ~reset;
  assign state_dbg = state;

endmodule
